// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM states, update-queue entry, default widths.
package bru_pkg;

    localparam int BRU_ADDR_W = 32;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [BRU_ADDR_W-1:0] pc;
        logic [BRU_ADDR_W-1:0] target;
        logic                  taken;
    } upd_entry_t;

    function automatic logic [63:0] sat_inc(input logic [63:0] value);
        return (&value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/bru_upd_fifo.sv
// Predictor-update FIFO; a pop frees its slot in the same cycle, so push+pop on full succeeds.
module bru_upd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    // NOTE: storage is deliberately not reset; the cleared count marks every slot as empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branches against the predicted NPC, redirects fetch and queues predictor updates.
// Optional BRU_STATS_EN adds saturating 64-bit branch / mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int UPDQ_DEPTH = 2,
    parameter int ADDR_W     = BRU_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid_IF,
    input  logic [ADDR_W-1:0] pred_npc_IF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              stallE,
    input  logic              flushE,
    input  logic              is_br_EX,
    input  logic              br_taken_EX,
    input  logic [ADDR_W-1:0] br_target_EX,
    input  logic [ADDR_W-1:0] PC_EX,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic [ADDR_W-1:0] upd_pc,
    output logic [ADDR_W-1:0] upd_target,
    output logic              upd_taken,
`ifdef BRU_STATS_EN
    output logic [63:0]       total_br,
    output logic [63:0]       mispred_cnt,
`endif
    output logic              upd_overflow
);

    localparam int ENTRY_W = 2 * ADDR_W + 1;

    bru_state_e        state;
    logic              valid_D;
    logic              valid_E;
    logic              resolved_E;
    logic [ADDR_W-1:0] npc_D;
    logic [ADDR_W-1:0] npc_E;
    logic [ADDR_W-1:0] correct_pc;
    logic              resolve;
    logic              mispredict;
    logic              q_full;
    logic              q_empty;
    logic              upd_pop;
    logic [ENTRY_W-1:0] q_dout;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        correct_pc = br_taken_EX ? br_target_EX : PC_EX + ADDR_W'(4);
        resolve    = valid_E && is_br_EX && (state == RUN) && !resolved_E;
        mispredict = resolve && (npc_E != correct_pc);
    end

    assign redirect    = mispredict;
    assign redirect_pc = correct_pc;

    // NOTE: sequential state uses non-blocking assignments so each register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            valid_D      <= 1'b0;
            valid_E      <= 1'b0;
            npc_D        <= '0;
            npc_E        <= '0;
            resolved_E   <= 1'b0;
            upd_overflow <= 1'b0;
        end else begin
            if (state == SQUASH) begin
                valid_D <= 1'b0;
            end else if (!stallD) begin
                if (flushD) begin
                    valid_D <= 1'b0;
                end else begin
                    valid_D <= pred_valid_IF;
                    npc_D   <= pred_npc_IF;
                end
            end

            if (state == SQUASH) begin
                valid_E <= 1'b0;
            end else if (!stallE) begin
                if (flushE) begin
                    valid_E <= 1'b0;
                end else begin
                    valid_E <= valid_D;
                    npc_E   <= npc_D;
                end
            end

            // A stalled EX instruction keeps its resolved mark so it enqueues only once.
            resolved_E <= stallE ? (resolved_E || resolve) : 1'b0;

            case (state)
                RUN:     if (mispredict) state <= SQUASH;
                SQUASH:  state <= RUN;
                default: state <= RUN;
            endcase

            if (resolve && q_full && !upd_pop) upd_overflow <= 1'b1;
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            total_br    <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve)    total_br    <= sat_inc(total_br);
            if (mispredict) mispred_cnt <= sat_inc(mispred_cnt);
        end
    end
`endif

    assign upd_valid = !q_empty;
    assign upd_pop   = upd_valid && upd_ready;
    assign {upd_pc, upd_target, upd_taken} = q_dout;

    bru_upd_fifo #(
        .DEPTH (UPDQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_upd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (resolve),
        .din   ({PC_EX, br_target_EX, br_taken_EX}),
        .pop   (upd_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a per-cycle reference model and literal spot checks.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = 32;

    logic          clk;
    logic          rst;
    logic          pred_valid_IF;
    logic [AW-1:0] pred_npc_IF;
    logic          stallD, flushD, stallE, flushE;
    logic          is_br_EX, br_taken_EX;
    logic [AW-1:0] br_target_EX, PC_EX;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          upd_valid, upd_ready;
    logic [AW-1:0] upd_pc, upd_target;
    logic          upd_taken;
    logic          upd_overflow;
`ifdef BRU_STATS_EN
    logic [63:0]   total_br, mispred_cnt;
`endif

    branch_resolve_unit #(.UPDQ_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pred_valid_IF(pred_valid_IF),
        .pred_npc_IF  (pred_npc_IF),
        .stallD       (stallD),
        .flushD       (flushD),
        .stallE       (stallE),
        .flushE       (flushE),
        .is_br_EX     (is_br_EX),
        .br_taken_EX  (br_taken_EX),
        .br_target_EX (br_target_EX),
        .PC_EX        (PC_EX),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
`ifdef BRU_STATS_EN
        .total_br     (total_br),
        .mispred_cnt  (mispred_cnt),
`endif
        .upd_overflow (upd_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the two in-flight predictions, squash window, update queue.
    bit              m_live = 0;
    bit              m_sq, m_vD, m_vE, m_done, m_ovf;
    logic [AW-1:0]   m_nD, m_nE;
    upd_entry_t      m_q[$];
    longint unsigned m_tot, m_mis;

    function automatic logic [AW-1:0] right_npc();
        return br_taken_EX ? br_target_EX : PC_EX + 32'd4;
    endfunction

    function automatic bit m_resolve();
        return m_vE && is_br_EX && !m_sq && !m_done;
    endfunction

    always @(posedge clk) begin : model
        bit r, mp;
        upd_entry_t e;
        if (rst) begin
            m_live = 1; m_sq = 0; m_vD = 0; m_vE = 0; m_done = 0; m_ovf = 0;
            m_nD = '0; m_nE = '0; m_q.delete(); m_tot = 0; m_mis = 0;
        end else if (m_live) begin
            r  = m_resolve();
            mp = r && (m_nE != right_npc());
            if (upd_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (r) begin
                e = '{pc: PC_EX, target: br_target_EX, taken: br_taken_EX};
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else m_ovf = 1;
                m_tot++;
            end
            if (mp) m_mis++;
            if (m_sq) m_vE = 0;
            else if (!stallE) begin
                if (flushE) m_vE = 0;
                else begin m_vE = m_vD; m_nE = m_nD; end
            end
            m_done = stallE ? (m_done || r) : 1'b0;
            if (m_sq) m_vD = 0;
            else if (!stallD) begin
                if (flushD) m_vD = 0;
                else begin m_vD = pred_valid_IF; m_nD = pred_npc_IF; end
            end
            m_sq = mp;
        end
    end

    always @(negedge clk) begin : compare
        bit exp_redir;
        if (m_live && !rst) begin
            exp_redir = m_resolve() && (m_nE != right_npc());
            check("redirect", 64'(redirect), 64'(exp_redir));
            if (exp_redir) check("redirect_pc", 64'(redirect_pc), 64'(right_npc()));
            check("upd_valid", 64'(upd_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("upd_pc", 64'(upd_pc), 64'(m_q[0].pc));
                check("upd_target", 64'(upd_target), 64'(m_q[0].target));
                check("upd_taken", 64'(upd_taken), 64'(m_q[0].taken));
            end
            check("upd_overflow", 64'(upd_overflow), 64'(m_ovf));
`ifdef BRU_STATS_EN
            check("total_br", total_br, m_tot);
            check("mispred_cnt", mispred_cnt, m_mis);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] npc);
        pred_valid_IF = 1'b1;
        pred_npc_IF   = npc;
        cyc();
        pred_valid_IF = 1'b0;
    endtask

    task automatic br(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg);
        is_br_EX     = 1'b1;
        PC_EX        = pc;
        br_taken_EX  = tk;
        br_target_EX = tg;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        pred_valid_IF = 0; pred_npc_IF = '0;
        stallD = 0; flushD = 0; stallE = 0; flushE = 0;
        is_br_EX = 0; br_taken_EX = 0; br_target_EX = '0; PC_EX = '0;
        upd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("reset_upd_valid", 64'(upd_valid), 64'd0);
        check("reset_redirect", 64'(redirect), 64'd0);
        check("reset_overflow", 64'(upd_overflow), 64'd0);

        // Correctly predicted not-taken branch at 0x100.
        fetch(32'h104); cyc();
        br(32'h100, 1'b0, 32'h180);
        #2 check("nt_redirect", 64'(redirect), 64'd0);
        cyc(); is_br_EX = 0;
        #2 check("nt_upd_valid", 64'(upd_valid), 64'd1);
        check("nt_upd_pc", 64'(upd_pc), 64'h100);
        check("nt_upd_taken", 64'(upd_taken), 64'd0);
        cyc();
        #2 check("nt_drained", 64'(upd_valid), 64'd0);

        // Mispredict: predicted 0x104, taken to 0x200; wrong-path follower suppressed.
        pred_valid_IF = 1; pred_npc_IF = 32'h104; cyc();
        pred_npc_IF = 32'h300; cyc();
        pred_valid_IF = 0;
        br(32'h100, 1'b1, 32'h200);
        #2 check("mp_redirect", 64'(redirect), 64'd1);
        check("mp_redirect_pc", 64'(redirect_pc), 64'h200);
        cyc();
        br(32'h200, 1'b1, 32'h400);
        #2 check("squash_suppress", 64'(redirect), 64'd0);
        check("mp_upd_target", 64'(upd_target), 64'h200);
        check("mp_upd_taken", 64'(upd_taken), 64'd1);
        cyc();
        #2 check("squash_no_enqueue", 64'(upd_valid), 64'd0);
        check("squash_cleared", 64'(redirect), 64'd0);
        is_br_EX = 0; cyc();

        // Three resolutions with the queue blocked: third one is dropped.
        upd_ready = 0;
        pred_valid_IF = 1; pred_npc_IF = 32'h14; cyc();
        pred_npc_IF = 32'h24; cyc();
        pred_npc_IF = 32'h34; br(32'h10, 1'b0, 32'h80); cyc();
        pred_valid_IF = 0; br(32'h20, 1'b0, 32'h80); cyc();
        br(32'h30, 1'b0, 32'h80);
        #2 check("ovf_not_yet", 64'(upd_overflow), 64'd0);
        cyc(); is_br_EX = 0;
        #2 check("ovf_set", 64'(upd_overflow), 64'd1);
        check("ovf_head", 64'(upd_pc), 64'h10);

        // Full queue with push and pop in the same cycle: nothing lost.
        fetch(32'h44); cyc();
        br(32'h40, 1'b0, 32'h80); upd_ready = 1;
        cyc(); is_br_EX = 0; upd_ready = 0;
        #2 check("full_pp_head", 64'(upd_pc), 64'h20);
        upd_ready = 1; cyc();
        #2 check("full_pp_kept", 64'(upd_pc), 64'h40);
        cyc();
        #2 check("full_pp_empty", 64'(upd_valid), 64'd0);

        // Branch stalled in EX for three cycles enqueues once.
        upd_ready = 0;
        fetch(32'h504); cyc();
        br(32'h500, 1'b0, 32'h900); stallE = 1;
        repeat (3) cyc();
        stallE = 0; cyc(); is_br_EX = 0;
        #2 check("stall_head", 64'(upd_pc), 64'h500);
        upd_ready = 1; cyc();
        #2 check("stall_single", 64'(upd_valid), 64'd0);

        // flushE kills the EX slot.
        fetch(32'h904); flushE = 1; cyc(); flushE = 0;
        br(32'h900, 1'b1, 32'ha00);
        #2 check("flushE_no_redirect", 64'(redirect), 64'd0);
        cyc(); is_br_EX = 0;

        // Reset in SQUASH with one queued entry.
        upd_ready = 0;
        fetch(32'h604); cyc();
        br(32'h600, 1'b1, 32'h700);
        #2 check("rst_mp_redirect", 64'(redirect), 64'd1);
        cyc(); is_br_EX = 0;
        #2 check("rst_pre_queued", 64'(upd_valid), 64'd1);
        rst = 1; cyc(); rst = 0;
        #2 check("rst_upd_valid", 64'(upd_valid), 64'd0);
        check("rst_overflow", 64'(upd_overflow), 64'd0);
`ifdef BRU_STATS_EN
        check("rst_total_br", total_br, 64'd0);
        check("rst_mispred", mispred_cnt, 64'd0);
`endif
        fetch(32'h804); cyc();
        br(32'h800, 1'b1, 32'h900);
        #2 check("post_rst_run", 64'(redirect), 64'd1);
        cyc(); is_br_EX = 0; upd_ready = 1;
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter UPDQ_DEPTH, default 2, update-queue entries (power of two, >=2).
REQ-002 Parameter ADDR_W, default 32, instruction-address width.
REQ-003 clk  in  1  single clock, all state on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pred_valid_IF  in  1  IF slot holds a real instruction.
REQ-006 pred_npc_IF  in  ADDR_W  NPC chosen by predictor for the IF instruction.
REQ-007 stallD / flushD / stallE / flushE  in  1 each  hazard-unit controls for the ID and EX latches.
REQ-008 is_br_EX  in  1  EX instruction is a conditional branch.
REQ-009 br_taken_EX  in  1  resolved direction.
REQ-010 br_target_EX, PC_EX  in  ADDR_W  resolved target, branch address.
REQ-011 redirect  out  1  misprediction; IF must fetch redirect_pc next cycle.
REQ-012 redirect_pc  out  ADDR_W  correct next address.
REQ-013 upd_valid / upd_ready  out / in  1  update handshake toward predictor tables.
REQ-014 upd_pc, upd_target  out  ADDR_W; upd_taken  out  1  update payload.
REQ-015 upd_overflow  out  1  sticky, update dropped because queue full.

Function
REQ-016 Predicted NPC SHALL travel IF->ID->EX in two registers (npc_D, npc_E) each with a valid bit; stall holds, flush clears valid, else load from previous stage.
REQ-017 Resolution SHALL occur only when valid_E && is_br_EX && fsm==RUN; correct_pc = br_taken_EX ? br_target_EX : PC_EX+4 (ADDR_W modular add).
REQ-018 Mispredict SHALL be npc_E != correct_pc; redirect and redirect_pc SHALL be combinational in the same cycle (zero latency).
REQ-019 FSM states RUN, SQUASH: RUN->SQUASH on mispredict; SQUASH->RUN after exactly one cycle; in SQUASH valid_D and valid_E SHALL be forced to 0 on the next edge and redirect held 0.
REQ-020 Every resolution (correct or not) SHALL enqueue {PC_EX, br_target_EX, br_taken_EX}; one enqueue per cycle max.
REQ-021 Queue SHALL be FIFO; upd_valid = not empty; head popped on upd_valid && upd_ready.
REQ-022 Simultaneous push and pop on full queue SHALL succeed (pop frees slot in same cycle).
REQ-023 Push on full without pop SHALL drop the new entry and set upd_overflow until rst.
REQ-024 Pointers SHALL wrap modulo UPDQ_DEPTH; count width clog2(UPDQ_DEPTH)+1.
REQ-025 stallE during resolution SHALL NOT re-enqueue: one enqueue per EX instruction, tracked by a resolved_E flag cleared when EX latch loads.

Reset
REQ-026 On rst: fsm=RUN, valid_D=valid_E=0, npc_D=npc_E=0, queue empty, upd_overflow=0, redirect=0, upd_valid=0, counters 0.
REQ-027 rst mid-SQUASH or with queue non-empty SHALL discard all state; no update emitted after rst edge.

Configuration
REQ-028 Macro BRU_STATS_EN: when defined, 64-bit counters total_br and mispred_cnt (outputs) increment per resolution/mispredict, saturating at all-ones; when undefined, ports and counters absent and no other behaviour changes.

Structure
REQ-029 Shared package bru_pkg SHALL hold fsm state enum, upd_entry_t struct {pc,target,taken}, ADDR_W default.
REQ-030 Queue SHALL be sub-module bru_upd_fifo (parameterized depth/width, push/pop/full/empty).

Verification
REQ-031 Predicted 0x104 for branch at 0x100, not-taken -> no redirect, one update {0x100,target,0}.
REQ-032 Predicted 0x104, taken to 0x200 -> redirect=1, redirect_pc=0x200 same cycle; next cycle fsm=SQUASH, following resolution suppressed.
REQ-033 upd_ready=0, three resolutions with UPDQ_DEPTH=2 -> first two held, third dropped, upd_overflow=1.
REQ-034 Full queue, push and upd_ready=1 same cycle -> no drop, count stays 2.
REQ-035 stallE=1 for 3 cycles on a branch in EX -> exactly one update entry.
REQ-036 rst asserted in SQUASH with 1 queued entry -> next cycle upd_valid=0, fsm=RUN; with BRU_STATS_EN counters read 0.
